rtc_bus_cycle: RTL and testbench

RTC_BUS_CYCLE -- requirements
Module: rtc_bus_cycle

---
 rtl/rtc_bus_cycle_if.sv | 26 ++
 rtl/rtc_bus_cycle.sv | 123 ++++++++++++
 tb/tb_rtc_bus_cycle.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_cycle_if.sv
// RTC bus cycle handshake and strobe bundle.
// The master side is the upstream sequencer; the slave side is the cycle FSM.
interface rtc_bus_cycle_if;
    logic w_r;
    logic do_it;
    logic a_d;
    logic cs;
    logic rd;
    logic wr;
    logic send_add;
    logic send_data;
    logic read_data;
    logic done;

    modport master (
        output w_r, do_it,
        input  a_d, cs, rd, wr,
        input  send_add, send_data, read_data, done
    );

    modport slave (
        input  w_r, do_it,
        output a_d, cs, rd, wr,
        output send_add, send_data, read_data, done
    );
endinterface

// File: rtl/rtc_bus_cycle.sv
// Fixed 35-clk multiplexed RTC bus cycle generator.
// Moore outputs are decoded from the state and cycle counter only.
module rtc_bus_cycle (
    input  logic           clk,
    input  logic           reset,
    rtc_bus_cycle_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP,
        DATA,
        RECOV
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] c_q, c_d;
    logic       w_r_q, w_r_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= 6'd0;
            w_r_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            w_r_q   <= w_r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q + 6'd1;
        w_r_d   = w_r_q;
        unique case (state_q)
            IDLE: begin
                c_d = 6'd0;
                if (bus.do_it) begin
                    state_d = ADDR;
                    w_r_d   = bus.w_r;
                end
            end
            ADDR: begin
                if (c_q == 6'd10) state_d = GAP;
            end
            GAP: begin
                if (c_q == 6'd13) state_d = DATA;
            end
            DATA: begin
                if (c_q == 6'd30) state_d = RECOV;
            end
            RECOV: begin
                if (c_q == 6'd34) begin
                    c_d = 6'd0;
                    // Back-to-back requests re-latch direction here
                    if (bus.do_it) begin
                        state_d = ADDR;
                        w_r_d   = bus.w_r;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                c_d     = 6'd0;
            end
        endcase
    end

    logic a_d, cs, rd, wr;
    logic send_add, send_data, read_data, done;
    logic addr_cs, addr_wr, data_cs, data_st, data_rv;

    assign addr_cs = (c_q >= 6'd2)  && (c_q <= 6'd8);
    assign addr_wr = (c_q >= 6'd3)  && (c_q <= 6'd7);
    assign data_cs = (c_q >= 6'd16) && (c_q <= 6'd28);
    assign data_st = (c_q >= 6'd17) && (c_q <= 6'd27);
    assign data_rv = (c_q >= 6'd26) && (c_q <= 6'd27);

    always_comb begin
        a_d       = 1'b1;
        cs        = 1'b1;
        rd        = 1'b1;
        wr        = 1'b1;
        send_add  = 1'b0;
        send_data = 1'b0;
        read_data = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ADDR: begin
                a_d      = 1'b0;
                send_add = 1'b1;
                cs       = ~addr_cs;
                wr       = ~addr_wr;
            end
            DATA: begin
                cs = ~data_cs;
                if (w_r_q) begin
                    send_data = 1'b1;
                    wr        = ~data_st;
                end else begin
                    rd        = ~data_st;
                    read_data = data_rv;
                end
            end
            RECOV: begin
                done = (c_q == 6'd34);
            end
            default: ;
        endcase
    end

    assign bus.a_d       = a_d;
    assign bus.cs        = cs;
    assign bus.rd        = rd;
    assign bus.wr        = wr;
    assign bus.send_add  = send_add;
    assign bus.send_data = send_data;
    assign bus.read_data = read_data;
    assign bus.done      = done;
endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Scoreboard bench for the RTC bus cycle generator.
// Each started transaction queues 35 expected output vectors.
module tb_rtc_bus_cycle;
    logic clk;
    logic reset;

    rtc_bus_cycle_if bus ();

    rtc_bus_cycle dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] v;
        logic [5:0] c;
    } exp_t;

    localparam logic [7:0] IDLE_V = 8'hF0;

    exp_t q[$];
    int   dones[$];
    int   cyc;
    int   n_run;
    int   n_fail;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_vec(logic w, int c);
        logic a_d, cs, rd, wr, sa, sd, rv, dn;
        a_d = !(c <= 10);
        cs  = !((c >= 2 && c <= 8) ||
                (c >= 16 && c <= 28));
        wr  = !((c >= 3 && c <= 7) ||
                (w && c >= 17 && c <= 27));
        rd  = !(!w && c >= 17 && c <= 27);
        sa  = (c <= 10);
        sd  = w && c >= 14 && c <= 30;
        rv  = !w && (c == 26 || c == 27);
        dn  = (c == 34);
        return {a_d, cs, rd, wr, sa, sd, rv, dn};
    endfunction

    function automatic logic [7:0] obs();
        return {bus.a_d, bus.cs, bus.rd, bus.wr,
                bus.send_add, bus.send_data,
                bus.read_data, bus.done};
    endfunction

    task automatic step();
        exp_t e;
        logic busy;
        logic csw;
        int   nf;
        if (q.size() == 0 && bus.do_it && !reset)
            for (int c = 0; c < 35; c++)
                q.push_back('{exp_vec(bus.w_r, c), 6'(c)});
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0) begin
            e    = q.pop_front();
            busy = 1'b1;
        end else begin
            e.v  = IDLE_V;
            e.c  = 6'd0;
            busy = 1'b0;
        end
        check("vec", 32'(obs()), 32'(e.v));
        nf = int'(bus.send_add) + int'(bus.send_data)
           + int'(bus.read_data);
        check("excl", 32'(nf > 1), 32'd0);
        check("rdwr", 32'(!bus.rd && !bus.wr), 32'd0);
        csw = busy && ((e.c >= 2 && e.c <= 8) ||
                       (e.c >= 16 && e.c <= 28));
        check("cs_win", 32'(!bus.cs && !csw), 32'd0);
        if (bus.done) dones.push_back(cyc);
    endtask

    int start;

    initial begin
        n_run      = 0;
        n_fail     = 0;
        cyc        = 0;
        reset      = 1'b1;
        bus.do_it  = 1'b0;
        bus.w_r    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst", 32'(obs()), 32'(IDLE_V));
        reset = 1'b0;
        repeat (3) step();

        // single write, one-clk request
        bus.w_r   = 1'b1;
        bus.do_it = 1'b1;
        step();
        bus.do_it = 1'b0;
        repeat (40) step();

        // single read, request dropped at c=20
        bus.w_r   = 1'b0;
        bus.do_it = 1'b1;
        repeat (21) step();
        bus.do_it = 1'b0;
        repeat (20) step();

        // back-to-back writes
        dones.delete();
        bus.w_r   = 1'b1;
        bus.do_it = 1'b1;
        step();
        start = cyc;
        for (int j = 1; j < 252; j++) begin
            if (j >= 211) bus.do_it = 1'b0;
            step();
        end
        check("b2b_n", 32'(dones.size()), 32'd7);
        if (dones.size() >= 7) begin
            for (int i = 1; i < 7; i++)
                check("b2b_gap",
                      32'(dones[i] - dones[i-1]), 32'd35);
            check("b2b_len",
                  32'(dones[6] - start + 1), 32'd245);
        end

        // w_r toggled at c=15 of a write
        bus.w_r   = 1'b1;
        bus.do_it = 1'b1;
        repeat (16) step();
        bus.w_r = 1'b0;
        repeat (20) step();
        bus.do_it = 1'b0;
        repeat (40) step();

        // reset at c=20 of a write
        bus.w_r   = 1'b1;
        bus.do_it = 1'b1;
        repeat (21) step();
        bus.do_it = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", 32'(obs()), 32'(IDLE_V));
        q.delete();
        @(posedge clk);
        #1;
        check("rst_hold", 32'(obs()), 32'(IDLE_V));
        reset = 1'b0;
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed",
                 n_run, n_fail);
        $finish;
    end
endmodule
